maze_input_conditioner: RTL and testbench
=========================================

Name: maze_input_conditioner

Overview:
- Sits directly upstream of the maze controller; feeds its Up/Down/Left/Right/Reset inputs and its move_clk.
- Synchronizes and debounces five raw board pushbuttons.
- Suppresses contradictory direction pairs.
- Generates the divided move_clk, plus a game-reset pulse that spans one full move_clk period. This guarantees the controller's move_clk-domain state machine re-enters INI cleanly.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clk cycles an input must be stable before its debounced level changes (10 ms at 100 MHz); must be >= 2
MOVE_DIV, 500_000, clk cycles per move_clk half-period (100 Hz move_clk at 100 MHz); must be >= 2

Ports:
clk  input  1  system clock (100 MHz)
Reset  input  1  asynchronous, active-low reset
BtnU  input  1  raw up button, asynchronous, active-high
BtnD  input  1  raw down button
BtnL  input  1  raw left button
BtnR  input  1  raw right button
BtnC  input  1  raw centre button (game restart)
Up  output  1  debounced, conflict-filtered up level
Down  output  1  debounced, conflict-filtered down level
Left  output  1  debounced, conflict-filtered left level
Right  output  1  debounced, conflict-filtered right level
move_clk  output  1  registered square wave, period 2*MOVE_DIV clk cycles
game_reset  output  1  active-high restart level for the controller's Reset input

Behaviour:
- Reset asserted (low) forces the following immediately and asynchronously:
  - all synchronizer flops 0; all debouncers IDLE, count 0
  - Up/Down/Left/Right 0; move_clk 0; divider count 0
  - game_reset 1 (power-on restart)
- Synchronizer: 2 flops per button; no logic between the stages.
- Debouncer FSM, per button, operating on synchronized input s:
  - IDLE: s=1 -> WAIT_PRESS, count <= 0.
  - WAIT_PRESS: s=0 -> IDLE. Else count++. At count == DEBOUNCE_CYCLES-1 -> PRESSED, level <= 1, rise pulse 1 for one cycle.
  - PRESSED: s=0 -> WAIT_RELEASE, count <= 0.
  - WAIT_RELEASE: s=1 -> PRESSED. Else count++. At count == DEBOUNCE_CYCLES-1 -> IDLE, level <= 0.
  - Latency: a clean raw edge changes the level exactly DEBOUNCE_CYCLES+2 clk cycles after the raw edge.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts qualification; the level never changes on a glitch.
  - Counter width: clog2(DEBOUNCE_CYCLES); the counter never wraps.
- Direction filter (registered, +1 cycle):
  - Up = dU & ~dD; Down = dD & ~dU; Left = dL & ~dR; Right = dR & ~dL.
  - Opposite pairs held together give 0 for both. Orthogonal combinations pass unchanged; the controller applies its own priority.
- move_clk divider:
  - Count runs 0..MOVE_DIV-1.
  - At MOVE_DIV-1: count <= 0 and move_clk toggles.
  - Free-running; unaffected by buttons or game_reset.
- game_reset FSM, states GR_IDLE, GR_ARMED, GR_HOLD:
  - Entered at GR_ARMED on reset, and from GR_IDLE on the BtnC debounced rise pulse. game_reset = 1 in GR_ARMED and GR_HOLD.
  - GR_ARMED: on the clk cycle where move_clk goes 0->1 -> GR_HOLD.
  - GR_HOLD: on the clk cycle where move_clk goes 1->0 -> GR_IDLE, game_reset <= 0.
  - Net effect: game_reset covers at least one full move_clk high phase and deasserts while move_clk is low, so the controller's Reset release never coincides with a move_clk rising edge.
  - BtnC rise pulse while in GR_ARMED or GR_HOLD is ignored; no re-trigger extension.
  - Holding BtnC produces exactly one restart; a new restart needs a release, then a re-press.
- Reset asserted mid-debounce or mid-hold returns every FSM to its reset state. game_reset stays 1 throughout.

Decomposition:
- Shared package maze_pkg holds:
  - debounce state encoding (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE)
  - game_reset state encoding
  - colour constants already used by the controller
- One sub-module: button_debouncer (synchronizer + FSM + counter, parameter DEBOUNCE_CYCLES, outputs level and rise pulse), instantiated 5 times.
- Divider and game_reset FSM stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, MOVE_DIV=3.
1. Reset low 5 cycles, then high -> Up/Down/Left/Right=0, move_clk=0, game_reset=1; game_reset falls on the first move_clk 1->0 edge (clk cycle 6 after release) and stays 0.
2. BtnU raised and held -> Up=0 for 6 cycles after the edge, then 1 at cycle 7 (6 debounce + 1 filter); release -> Up falls 7 cycles after the release.
3. BtnR pulsed high for 3 cycles, low 2, high 3 -> Right stays 0 throughout.
4. BtnL held stable, then BtnR added stable -> Left=1, then both Left and Right=0 once R qualifies; release R -> Left returns to 1.
5. Free-run 24 cycles after reset -> move_clk toggles every 3 cycles (4 full periods); press BtnU mid-run -> toggle timing unchanged.
6. BtnC pressed and held 30 cycles while game_reset=0 -> exactly one game_reset assertion, spanning one move_clk rise and ending on the next fall; second press after release -> second assertion.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: button indices, debouncer and
// restart state encodings, and the colour constants used by the controller.
package maze_pkg;

  localparam int NUM_BTNS = 5;
  localparam int BTN_U    = 0;
  localparam int BTN_D    = 1;
  localparam int BTN_L    = 2;
  localparam int BTN_R    = 3;
  localparam int BTN_C    = 4;

  // Buttons whose debounced press starts a game restart.
  localparam logic [NUM_BTNS-1:0] RESTART_BTN_MASK = 5'b10000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } db_state_e;

  typedef enum logic [1:0] {
    GR_IDLE,
    GR_ARMED,
    GR_HOLD
  } gr_state_e;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COLOR_BLACK  = 12'h000;
  localparam rgb_t COLOR_WHITE  = 12'hFFF;
  localparam rgb_t COLOR_WALL   = 12'h00F;
  localparam rgb_t COLOR_PLAYER = 12'hF00;
  localparam rgb_t COLOR_GOAL   = 12'h0F0;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a four-state debounce FSM; a level change
// needs DEBOUNCE_CYCLES consecutive identical synchronized samples.
module button_debouncer
  import maze_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The IDLE/PRESSED cycle that first sees the change is sample one, so the
  // wait states finish when the incremented count would reach N-1.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic            sync1_q, sync2_q;
  db_state_e       state_q;
  logic [CW-1:0]   count_q;
  logic            level_q, rise_q;

  // NOTE: non-blocking assignments make the two stages a true shift register;
  // blocking ones would collapse them into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= WAIT_PRESS;
            count_q <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync2_q) begin
            state_q <= IDLE;
          end else if (count_q == LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_q <= WAIT_RELEASE;
            count_q <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync2_q) begin
            state_q <= PRESSED;
          end else if (count_q == LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/maze_input_conditioner.sv
// Conditions the five board buttons for the maze controller: debounce,
// opposite-direction suppression, move_clk generation and restart pulse.
module maze_input_conditioner
  import maze_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MOVE_DIV        = 500_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnL,
  input  logic BtnR,
  input  logic BtnC,
  output logic Up,
  output logic Down,
  output logic Left,
  output logic Right,
  output logic move_clk,
  output logic game_reset
);

  localparam int unsigned DW = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MOVE_DIV - 1);

  logic [NUM_BTNS-1:0] btn_raw, btn_level, btn_rise;

  assign btn_raw = {BtnC, BtnR, BtnL, BtnD, BtnU};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (Reset),
      .btn_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .rise_o (btn_rise[i])
    );
  end

  logic up_q, down_q, left_q, right_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      up_q    <= btn_level[BTN_U] & ~btn_level[BTN_D];
      down_q  <= btn_level[BTN_D] & ~btn_level[BTN_U];
      left_q  <= btn_level[BTN_L] & ~btn_level[BTN_R];
      right_q <= btn_level[BTN_R] & ~btn_level[BTN_L];
    end
  end

  logic [DW-1:0] div_q;
  logic          move_clk_q;
  logic          div_wrap, mc_rise, mc_fall, restart_rise;

  assign div_wrap     = (div_q == DIV_LAST);
  assign mc_rise      = div_wrap & ~move_clk_q;
  assign mc_fall      = div_wrap &  move_clk_q;
  assign restart_rise = |(btn_rise & RESTART_BTN_MASK);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      div_q      <= '0;
      move_clk_q <= 1'b0;
    end else if (div_wrap) begin
      div_q      <= '0;
      move_clk_q <= ~move_clk_q;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  gr_state_e gr_q;
  logic      game_reset_q;

  // Restart holds through a full move_clk high phase and drops while move_clk
  // is low, so the controller never sees Reset release on its clock edge.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      gr_q         <= GR_ARMED;
      game_reset_q <= 1'b1;
    end else begin
      case (gr_q)
        GR_IDLE: begin
          if (restart_rise) begin
            gr_q         <= GR_ARMED;
            game_reset_q <= 1'b1;
          end
        end
        GR_ARMED: begin
          if (mc_rise) gr_q <= GR_HOLD;
        end
        GR_HOLD: begin
          if (mc_fall) begin
            gr_q         <= GR_IDLE;
            game_reset_q <= 1'b0;
          end
        end
        default: begin
          gr_q         <= GR_ARMED;
          game_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign Up         = up_q;
  assign Down       = down_q;
  assign Left       = left_q;
  assign Right      = right_q;
  assign move_clk   = move_clk_q;
  assign game_reset = game_reset_q;

endmodule

// File: tb/tb_maze_input_conditioner.sv
// Randomized and directed stimulus for maze_input_conditioner, compared every
// cycle against a sample-counting behavioural model.
module tb_maze_input_conditioner;

  localparam int N = 4;
  localparam int M = 3;

  logic clk = 1'b0;
  logic Reset;
  logic BtnU, BtnD, BtnL, BtnR, BtnC;
  logic Up, Down, Left, Right, move_clk, game_reset;

  always #5 clk = ~clk;

  maze_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .MOVE_DIV       (M)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .BtnU      (BtnU),
    .BtnD      (BtnD),
    .BtnL      (BtnL),
    .BtnR      (BtnR),
    .BtnC      (BtnC),
    .Up        (Up),
    .Down      (Down),
    .Left      (Left),
    .Right     (Right),
    .move_clk  (move_clk),
    .game_reset(game_reset)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: button bit order U,D,L,R,C. A debounced level flips once the
  // synchronized input has disagreed with it for N consecutive samples.
  logic [4:0] m_s1, m_s2, m_lvl;
  int         m_run [5];
  logic       m_rise;
  logic [3:0] m_dir;
  int         m_cyc;
  logic       m_gr, m_saw_high;

  function automatic logic mc_of(input int c);
    return ((c / M) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_rise = 1'b0; m_dir = '0; m_cyc = 0;
    m_gr = 1'b1; m_saw_high = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] b);
    logic old_mc, new_mc;
    old_mc = mc_of(m_cyc);
    new_mc = mc_of(m_cyc + 1);
    m_cyc++;
    m_dir[0] = m_lvl[0] & ~m_lvl[1];
    m_dir[1] = m_lvl[1] & ~m_lvl[0];
    m_dir[2] = m_lvl[2] & ~m_lvl[3];
    m_dir[3] = m_lvl[3] & ~m_lvl[2];
    if (m_gr) begin
      if (!old_mc && new_mc) m_saw_high = 1'b1;
      else if (m_saw_high && old_mc && !new_mc) m_gr = 1'b0;
    end else if (m_rise) begin
      m_gr = 1'b1;
      m_saw_high = 1'b0;
    end
    m_rise = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == N) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
        if (i == 4 && m_lvl[i]) m_rise = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic compare_all();
    check("up",         Up,         m_dir[0]);
    check("down",       Down,       m_dir[1]);
    check("left",       Left,       m_dir[2]);
    check("right",      Right,      m_dir[3]);
    check("move_clk",   move_clk,   mc_of(m_cyc));
    check("game_reset", game_reset, m_gr);
  endtask

  task automatic drive(input logic [4:0] b);
    {BtnC, BtnR, BtnL, BtnD, BtnU} = b;
  endtask

  // Called at a falling edge: apply inputs, advance model, check next cycle.
  task automatic step(input logic [4:0] b);
    drive(b);
    model_step(b);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic [4:0] b);
    drive(b);
    Reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(negedge clk);
    compare_all();
    Reset = 1'b1;
  endtask

  initial begin
    int         t;
    int         cnt;
    logic       prev;
    logic       seen;
    logic [4:0] b;

    Reset = 1'b0;
    drive('0);
    model_reset();
    repeat (5) @(negedge clk);
    #1;
    compare_all();
    check("reset_up", Up, 1'b0);
    check("reset_game_reset", game_reset, 1'b1);
    @(negedge clk);
    Reset = 1'b1;

    // Power-on restart drops on the first move_clk fall, six cycles in.
    t = 0;
    do begin
      step('0);
      t++;
    end while (game_reset && t < 20);
    check("gr_release_cycle", t, 6);
    repeat (10) step('0);
    check("gr_stays_low", game_reset, 1'b0);

    // Press and release latency on Up.
    t = 0;
    do begin
      step(5'b00001);
      t++;
    end while (!Up && t < 20);
    check("up_rise_latency", t, 7);
    repeat (4) step(5'b00001);
    t = 0;
    do begin
      step('0);
      t++;
    end while (Up && t < 20);
    check("up_fall_latency", t, 7);
    repeat (6) step('0);

    // Short glitches on Right never qualify.
    seen = 1'b0;
    foreach (b[i]) begin end
    for (int k = 0; k < 16; k++) begin
      step((k < 3 || (k >= 5 && k < 8)) ? 5'b01000 : 5'b00000);
      seen |= Right;
    end
    check("glitch_right", seen, 1'b0);

    // Left alone, then opposite Right added, then Right released.
    repeat (10) step(5'b00100);
    check("left_alone", Left, 1'b1);
    repeat (10) step(5'b01100);
    check("lr_left_blocked", Left, 1'b0);
    check("lr_right_blocked", Right, 1'b0);
    repeat (10) step(5'b00100);
    check("left_restored", Left, 1'b1);
    repeat (10) step('0);

    // Holding centre gives one restart; a release and re-press gives another.
    cnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 30; k++) begin
        prev = game_reset;
        step(5'b10000);
        if (!prev && game_reset) cnt++;
      end
      check("restart_count", cnt, p + 1);
      for (int k = 0; k < 15; k++) begin
        prev = game_reset;
        step('0);
        if (!prev && game_reset) cnt++;
      end
    end
    check("restart_count_final", cnt, 2);

    // Random button activity with occasional asynchronous resets.
    b = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(5) == 0) b[i] = ~b[i];
      if ($urandom_range(399) == 0) do_reset(b);
      step(b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
